// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the SAP-style microsequencer: opcodes, control-word
// bit positions, the idle word and the T-state encoding.
package cpu_ctrl_pkg;

  localparam int CW_W     = 15;
  localparam int EXEC_MAX = 3;

  typedef logic [CW_W-1:0] cw_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CW_CP   = 14;
  localparam int CW_EP   = 13;
  localparam int CW_LP   = 12;
  localparam int CW_NLMA = 11;
  localparam int CW_NLMD = 10;
  localparam int CW_NCE  = 9;
  localparam int CW_NLR  = 8;
  localparam int CW_NLI  = 7;
  localparam int CW_NEI  = 6;
  localparam int CW_NLA  = 5;
  localparam int CW_EA   = 4;
  localparam int CW_SUB  = 3;
  localparam int CW_EU   = 2;
  localparam int CW_NLB  = 1;
  localparam int CW_NLO  = 0;

  localparam cw_t CW_IDLE = 15'h0FE3;

  // T-state values double as the tstate output; WAIT encodes as 7 on purpose.
  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_HALT = 3'd6,
    S_WAIT = 3'd7
  } state_e;

  function automatic int exec_len(input logic [3:0] op);
    if (op == OP_LDA || op == OP_ADD || op == OP_SUB || op == OP_STA) return EXEC_MAX;
    return 1;
  endfunction

endpackage

// File: rtl/cpu_microsequencer_if.sv
// Sequencer-facing bundle: IR opcode, ALU flags, run/step controls in; control word and status out.
interface cpu_microsequencer_if;
  import cpu_ctrl_pkg::*;

  logic [3:0] opcode;
  logic       cf;
  logic       zf;
  logic       run;
  logic       step;
  cw_t        control_word;
  logic [2:0] tstate;
  logic       halted;

  modport master (
    output opcode, cf, zf, run, step,
    input  control_word, tstate, halted
  );

  modport slave (
    input  opcode, cf, zf, run, step,
    output control_word, tstate, halted
  );
endinterface

// File: rtl/step_edge_detect.sv
// Rising-edge detector for the single-step level input; history resets high so
// a step line already high at reset release is not taken as a fresh press.
module step_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic step_i,
  output logic rise_o
);
  logic step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_q <= 1'b1;
    else     step_q <= step_i;
  end

  assign rise_o = step_i & ~step_q;
endmodule

// File: rtl/cpu_microsequencer.sv
// Microcoded T-state sequencer: fetch T0-T2, opcode-dependent execute T3-T5,
// run/single-step gating at instruction boundaries and a sticky HALT.
module cpu_microsequencer
  import cpu_ctrl_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  cpu_microsequencer_if.slave bus
);
  state_e state_q, state_d;
  cw_t    cw;
  logic   step_rise;

  step_edge_detect u_step (
    .clk    (clk),
    .rst    (rst),
    .step_i (bus.step),
    .rise_o (step_rise)
  );

  function automatic state_e end_state(input logic run);
    return run ? S_T0 : S_WAIT;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: if (bus.run || step_rise) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3, S_T4, S_T5: begin
        if (state_q == S_T3 && bus.opcode == OP_HLT)
          state_d = S_HALT;
        else if ((int'(state_q) - 2) < exec_len(bus.opcode))
          state_d = state_e'(state_q + 3'd1);
        else
          state_d = end_state(bus.run);
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_WAIT;
    else     state_q <= state_d;
  end

  // Microcode ROM: start from the idle word and flip only the signals each step needs.
  always_comb begin
    cw = CW_IDLE;
    case (state_q)
      S_T0: begin cw[CW_EP] = 1'b1; cw[CW_NLMA] = 1'b0; end
      S_T1: cw[CW_CP] = 1'b1;
      S_T2: begin cw[CW_NCE] = 1'b0; cw[CW_NLI] = 1'b0; end
      S_T3: begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin cw[CW_NEI] = 1'b0; cw[CW_NLMA] = 1'b0; end
          OP_LDI: begin cw[CW_NEI] = 1'b0; cw[CW_NLA] = 1'b0; end
          OP_JMP: begin cw[CW_NEI] = 1'b0; cw[CW_LP]  = 1'b1; end
          OP_JC:  if (bus.cf) begin cw[CW_NEI] = 1'b0; cw[CW_LP] = 1'b1; end
          OP_JZ:  if (bus.zf) begin cw[CW_NEI] = 1'b0; cw[CW_LP] = 1'b1; end
          OP_OUT: begin cw[CW_EA]  = 1'b1; cw[CW_NLO] = 1'b0; end
          OP_NOP: ;
          default: ;
        endcase
      end
      S_T4: begin
        case (bus.opcode)
          OP_LDA:         begin cw[CW_NCE] = 1'b0; cw[CW_NLA]  = 1'b0; end
          OP_ADD, OP_SUB: begin cw[CW_NCE] = 1'b0; cw[CW_NLB]  = 1'b0; end
          OP_STA:         begin cw[CW_EA]  = 1'b1; cw[CW_NLMD] = 1'b0; end
          default: ;
        endcase
      end
      S_T5: begin
        case (bus.opcode)
          OP_ADD: begin cw[CW_EU] = 1'b1; cw[CW_NLA] = 1'b0; end
          OP_SUB: begin cw[CW_EU] = 1'b1; cw[CW_NLA] = 1'b0; cw[CW_SUB] = 1'b1; end
          OP_STA: cw[CW_NLR] = 1'b0;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Reset gates the word directly so a RAM write in flight is cut the same instant.
  assign bus.control_word = rst ? CW_IDLE : cw;
  assign bus.tstate       = (state_q == S_HALT) ? 3'd7 : 3'(state_q);
  assign bus.halted       = (state_q == S_HALT);
endmodule
